// File: rtl/parking_occupancy_if.sv
// Bundle between the sensor synchroniser / display side and the occupancy counter.
// The master drives the request and sensor snapshot; the slave publishes the occupancy statistics.
interface parking_occupancy_if #(
  parameter int NUM_SPOTS = 8
) ();
  localparam int CNT_W = $clog2(NUM_SPOTS + 1);

  logic                 start;
  logic [NUM_SPOTS-1:0] sensors;
  logic [CNT_W-1:0]     threshold;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     parked;
  logic [CNT_W-1:0]     free;
  logic                 full;
  logic                 empty;
  logic                 near_full;
  logic                 changed;
  logic [CNT_W-1:0]     max_parked;

  modport master (
    output start, sensors, threshold,
    input  busy, done, parked, free, full, empty, near_full, changed, max_parked
  );

  modport slave (
    input  start, sensors, threshold,
    output busy, done, parked, free, full, empty, near_full, changed, max_parked
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Sequential parked-car counter: snapshots the sensor vector on start, sums LANES bits
// per cycle, then publishes registered occupancy statistics with a one-cycle done pulse.
module parking_occupancy_counter #(
  parameter int NUM_SPOTS = 8,
  parameter int LANES     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parking_occupancy_if.slave   bus
);
  localparam int CNT_W = $clog2(NUM_SPOTS + 1);
  localparam int S     = (NUM_SPOTS + LANES - 1) / LANES;
  localparam int PAD_W = S * LANES;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] SPOTS_C  = CNT_W'(NUM_SPOTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t           state_q, state_d;
  logic [PAD_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] parked_q, parked_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             near_q, near_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [LANES-1:0] slice;
  logic             accept;

  // Snapshot is zero-padded up to S*LANES bits so the last partial slice adds nothing extra.
  assign slice = snap_q[int'(idx_q) * LANES +: LANES];

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    thr_d     = thr_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    parked_d  = parked_q;
    free_d    = free_q;
    full_d    = full_q;
    empty_d   = empty_q;
    near_d    = near_q;
    changed_d = changed_q;
    max_d     = max_q;
    accept    = 1'b0;

    case (state_q)
      IDLE: accept = bus.start;
      SCAN: begin
        acc_d = acc_q + popcount(slice);
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        done_d    = 1'b1;
        parked_d  = acc_q;
        free_d    = SPOTS_C - acc_q;
        full_d    = (acc_q == SPOTS_C);
        empty_d   = (acc_q == '0);
        near_d    = (acc_q >= thr_q);
        changed_d = (acc_q != parked_q);
        max_d     = max_cnt(max_q, acc_q);
        state_d   = IDLE;
        accept    = bus.start;
      end
      default: state_d = IDLE;
    endcase

    // A new request is taken from IDLE or straight out of DONE for back-to-back counts.
    if (accept) begin
      snap_d  = PAD_W'(bus.sensors);
      thr_d   = bus.threshold;
      acc_d   = '0;
      idx_d   = '0;
      state_d = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      thr_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      parked_q  <= '0;
      free_q    <= SPOTS_C;
      full_q    <= (NUM_SPOTS == 0);
      empty_q   <= 1'b1;
      near_q    <= 1'b0;
      changed_q <= 1'b0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      thr_q     <= thr_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      parked_q  <= parked_d;
      free_q    <= free_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      near_q    <= near_d;
      changed_q <= changed_d;
      max_q     <= max_d;
    end
  end

  assign bus.busy       = (state_q == SCAN);
  assign bus.done       = done_q;
  assign bus.parked     = parked_q;
  assign bus.free       = free_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.near_full  = near_q;
  assign bus.changed    = changed_q;
  assign bus.max_parked = max_q;
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Bench for parking_occupancy_counter: directed and random counts on an 8-spot instance,
// plus a 10-spot instance exercising the zero-padded final slice.
module tb_parking_occupancy_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parking_occupancy_if #(.NUM_SPOTS(8))  bus8 ();
  parking_occupancy_if #(.NUM_SPOTS(10)) bus10 ();

  parking_occupancy_counter #(.NUM_SPOTS(8), .LANES(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );
  parking_occupancy_counter #(.NUM_SPOTS(10), .LANES(4)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .bus(bus10)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model of the 8-spot instance: tracks what the published statistics must be.
  int m_parked = 0;
  int m_max    = 0;
  bit m_changed = 1'b0;
  bit m_near    = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_apply(input int cnt, input int thr);
    m_changed = (cnt != m_parked);
    m_parked  = cnt;
    if (cnt > m_max) m_max = cnt;
    m_near    = (cnt >= thr);
  endtask

  task automatic model_reset();
    m_parked = 0; m_max = 0; m_changed = 1'b0; m_near = 1'b0;
  endtask

  task automatic check8(input string tag);
    chk({tag, ".parked"},    int'(bus8.parked),     m_parked);
    chk({tag, ".free"},      int'(bus8.free),       8 - m_parked);
    chk({tag, ".full"},      int'(bus8.full),       int'(m_parked == 8));
    chk({tag, ".empty"},     int'(bus8.empty),      int'(m_parked == 0));
    chk({tag, ".near_full"}, int'(bus8.near_full),  int'(m_near));
    chk({tag, ".changed"},   int'(bus8.changed),    int'(m_changed));
    chk({tag, ".max"},       int'(bus8.max_parked), m_max);
  endtask

  // One count on the 8-spot instance: S=2, so busy for 2 cycles and done in the 4th cycle after E.
  task automatic do_count(input logic [7:0] s, input logic [3:0] th, input string tag);
    int n, busy_cyc;
    bit seen;
    @(negedge clk);
    bus8.start = 1'b1; bus8.sensors = s; bus8.threshold = th;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 1; busy_cyc = 0; seen = 1'b0;
    while (n <= 20 && !seen) begin
      if (bus8.busy) busy_cyc++;
      if (bus8.done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, ".latency"}, n, 4);
    chk({tag, ".busy_cycles"}, busy_cyc, 2);
    if (seen) begin
      model_apply($countones(s), int'(th));
      check8(tag);
    end
    @(negedge clk);
    chk({tag, ".done_pulse"}, int'(bus8.done), 0);
  endtask

  // One count on the 10-spot instance: S=3, busy for 3 cycles, done in the 5th cycle after E.
  task automatic do_count10(input logic [9:0] s, input string tag);
    int n, busy_cyc, c;
    bit seen;
    c = $countones(s);
    @(negedge clk);
    bus10.start = 1'b1; bus10.sensors = s; bus10.threshold = 4'd2;
    @(negedge clk);
    bus10.start = 1'b0;
    n = 1; busy_cyc = 0; seen = 1'b0;
    while (n <= 20 && !seen) begin
      if (bus10.busy) busy_cyc++;
      if (bus10.done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, ".latency"}, n, 5);
    chk({tag, ".busy_cycles"}, busy_cyc, 3);
    chk({tag, ".parked"}, int'(bus10.parked), c);
    chk({tag, ".free"},   int'(bus10.free),   10 - c);
    chk({tag, ".full"},   int'(bus10.full),   int'(c == 10));
    chk({tag, ".near"},   int'(bus10.near_full), int'(c >= 2));
  endtask

  initial begin
    int dones, last, cyc;
    logic [7:0] s;
    logic [3:0] th;

    bus8.start = 1'b1; bus8.sensors = 8'hFF; bus8.threshold = '0;
    bus10.start = 1'b0; bus10.sensors = '0; bus10.threshold = '0;

    // Reset with start held: reset must win.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy_with_start", int'(bus8.busy), 0);
    bus8.start = 1'b0;
    chk("rst.done", int'(bus8.done), 0);
    model_reset();
    check8("rst");
    chk("rst10.free",  int'(bus10.free), 10);
    chk("rst10.empty", int'(bus10.empty), 1);
    rst_n = 1'b1;

    // Directed sequence from the basic use cases.
    do_count(8'b1011_0110, 4'd4, "first");
    do_count(8'b1011_0110, 4'd4, "repeat");
    do_count(8'hFF, 4'd4, "all_full");
    do_count(8'h00, 4'd4, "all_empty");
    do_count(8'h81, 4'd0, "thr_zero");
    do_count(8'h7F, 4'd9, "thr_above");
    do_count(8'hFF, 4'd8, "thr_eq_full");

    // Padded final slice on the 10-spot instance.
    do_count10(10'b11_0000_0001, "pad3");
    do_count10(10'h3FF, "pad_full");

    // start and sensor changes during SCAN are ignored.
    @(negedge clk);
    bus8.start = 1'b1; bus8.sensors = 8'h01; bus8.threshold = 4'd4;
    @(negedge clk);
    bus8.start = 1'b1; bus8.sensors = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        dones++;
        model_apply(1, 4);
        check8("scan_ignore");
      end
    end
    chk("scan_ignore.done_count", dones, 1);

    // Back-to-back counts with start held high.
    @(negedge clk);
    bus8.start = 1'b1; bus8.sensors = 8'h0F; bus8.threshold = 4'd4;
    dones = 0; last = -1; cyc = 0;
    while (dones < 3 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bus8.sensors = (bus8.sensors == 8'h0F) ? 8'hF0 : 8'h0F;
      if (bus8.done) begin
        model_apply(4, 4);
        check8("b2b");
        if (last >= 0) chk("b2b.period", cyc - last, 3);
        last = cyc;
        dones++;
      end
    end
    chk("b2b.done_count", dones, 3);
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        model_apply(4, 4);
        check8("b2b_drain");
      end
    end

    // Reset in the middle of SCAN aborts the count and clears the peak.
    do_count(8'b1011_0110, 4'd4, "pre_abort");
    @(negedge clk);
    bus8.start = 1'b1; bus8.sensors = 8'hFF; bus8.threshold = 4'd4;
    @(negedge clk);
    bus8.start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus8.done) dones++;
    end
    chk("abort.done_count", dones, 0);
    chk("abort.busy", int'(bus8.busy), 0);
    model_reset();
    check8("abort");
    do_count(8'h3C, 4'd9, "post_abort");

    // Random counts against the model; thresholds span 0..15 including above NUM_SPOTS.
    for (int i = 0; i < 12; i++) begin
      s  = 8'($urandom);
      th = 4'($urandom_range(0, 15));
      do_count(s, th, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
